// File: rtl/instr_mem_responder.sv
// instr_mem_responder: answers instruction fetch requests one at a time.
// A request is accepted with a combinational grant, then waits LATENCY cycles
// and returns one registered valid/data/err beat. The preload port fills the
// array and flush cancels whatever request or response is in flight.
//
// Handshake: a request moves on a rising edge where instr_req_ip and
// instr_gnt_op are both high; instr_valid_op is a one-cycle pulse with no
// back-pressure, and instr_data_op/instr_err_op are meaningful only with it.
module instr_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_en,
    input  logic        flush_ip,
    input  logic        instr_req_ip,
    input  logic [31:0] instr_addr_ip,
    output logic        instr_gnt_op,
    output logic        instr_valid_op,
    output logic [31:0] instr_data_op,
    output logic        instr_err_op,
    input  logic        load_we_ip,
    input  logic [31:0] load_addr_ip,
    input  logic [31:0] load_data_ip,
    // Debug view of the FSM: 0 = IDLE, 1 = WAIT, 2 = RESP
    output logic [1:0]  dbg_state_op
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          req_bad;
    logic [31:0]   rd_word;
    logic [AW-1:0] load_idx;
    logic          load_in_range;

    assign load_idx      = load_addr_ip[AW+1:2];
    assign load_in_range = (load_addr_ip >> (AW + 2)) == 32'd0;

    // Grant only when no request is being serviced and nothing else owns the cycle
    always_comb begin
        instr_gnt_op = mem_en & ~flush_ip & ~load_we_ip
                     & ((state_q == S_IDLE) | (state_q == S_RESP));
        accept       = instr_req_ip & instr_gnt_op;
        req_bad      = (addr_q[1:0] != 2'b00) | ((addr_q >> (AW + 2)) != 32'd0);
        rd_word      = mem[addr_q[AW+1:2]];
    end

    // Preload writes; the array itself is deliberately never reset
    always_ff @(posedge clock) begin
        if (load_we_ip && load_in_range) begin
            mem[load_idx] <= load_data_ip;
        end
    end

    // Next-state and response logic; flush always beats a completing read
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        valid_d = 1'b0;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(LATENCY - 1);
                    addr_d  = instr_addr_ip;
                end
            end
            S_WAIT: begin
                if (flush_ip) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    valid_d = 1'b1;
                    data_d  = req_bad ? NOP_WORD : rd_word;
                    err_d   = req_bad;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (accept) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(LATENCY - 1);
                    addr_d  = instr_addr_ip;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            valid_q <= 1'b0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign instr_valid_op = valid_q;
    assign instr_data_op  = data_q;
    assign instr_err_op   = err_q;
    assign dbg_state_op   = state_q;

endmodule
